div_16_8_seq: RTL and testbench

- Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor -> 16-bit quotient + 8-bit remainder.
- Inverse datapath of the 8x8 multiplier. One quotient bit per cycle through a shared trial subtractor.
- valid/ready handshake on both ends; drops into the arithmetic pipeline next to the multiplier.

---
 rtl/div_16_8_seq_pkg.sv | 23 ++
 rtl/div_16_8_seq_sub9_trial.sv | 46 ++++
 rtl/div_16_8_seq.sv | 166 ++++++++++++++++
 tb/tb_div_16_8_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_16_8_seq_pkg.sv
// Shared constants and types for the 16/8 sequential restoring divider.
//   DIVIDEND_W    : dividend / quotient width
//   DIVISOR_W     : divisor / remainder width
//   CNT_W         : iteration counter width (2**CNT_W > DIVIDEND_W)
//   LAST_ITER     : counter value on the final quotient-bit iteration
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
//   state_t       : controller states
package div_16_8_seq_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0]      LAST_ITER     = 5'd15;
    localparam logic [DIVIDEND_W-1:0] DIV_ZERO_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_16_8_seq_pkg

// File: rtl/div_16_8_seq_sub9_trial.sv
// 9-bit trial subtractor for the restoring divider: diff = a - b computed as
// a + ~b + 1 with two 4-bit ripple adder stages plus a final 1-bit stage, so
// the path is built the same way as the multiplier's adders.
//   a      : minuend (shifted partial remainder)
//   b      : subtrahend (zero-extended divisor)
//   diff   : a - b modulo 2**9
//   borrow : 1 when a < b (trial result negative)
module sub9_trial (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       borrow
);

    // 4-bit ripple-carry adder cell; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] add4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       cin);
        logic [4:0] res;
        logic       c;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            res[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        res[4] = c;
        return res;
    endfunction

    logic [4:0] lo_s;
    logic [4:0] mid_s;
    logic       top_sum_s;
    logic       top_cout_s;

    // Ripple a + ~b + 1 through two nibble cells and the ninth bit.
    always_comb begin
        lo_s       = add4(a[3:0], ~b[3:0], 1'b1);
        mid_s      = add4(a[7:4], ~b[7:4], lo_s[4]);
        top_sum_s  = a[8] ^ ~b[8] ^ mid_s[4];
        top_cout_s = (a[8] & ~b[8]) | (a[8] & mid_s[4]) | (~b[8] & mid_s[4]);
        diff       = {top_sum_s, mid_s[3:0], lo_s[3:0]};
        // No carry out of a + ~b + 1 means the subtraction wrapped.
        borrow     = ~top_cout_s;
    end

endmodule : sub9_trial

// File: rtl/div_16_8_seq.sv
// Sequential restoring divider, 16-bit unsigned dividend / 8-bit unsigned
// divisor, one quotient bit per clock through a shared trial subtractor.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid / in_ready : operand handshake (accept when both high)
//   dividend, divisor   : operands, sampled only at the accept edge
//   out_valid/out_ready : result handshake
//   quotient, remainder : result (held after the handshake)
//   div_zero            : result came from a zero divisor
module div_16_8_seq
    import div_16_8_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DIVIDEND_W-1:0]   q_r;
    logic [DIVISOR_W-1:0]    d_r;
    logic [DIVISOR_W:0]      r_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [DIVIDEND_W-1:0]   quotient_r;
    logic [DIVISOR_W-1:0]    remainder_r;
    logic                    div_zero_r;

    logic                    accept_s;
    logic [DIVISOR_W:0]      shifted_s;
    logic [DIVISOR_W:0]      diff_s;
    logic                    borrow_s;
    logic [DIVISOR_W:0]      r_nxt_s;
    logic [DIVIDEND_W-1:0]   q_nxt_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

    sub9_trial u_trial (
        .a      (shifted_s),
        .b      ({1'b0, d_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // One restoring step: shift next dividend bit into R and keep the
    // subtraction only when it did not go negative.
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        shifted_s = {r_r[DIVISOR_W-1:0], q_r[DIVIDEND_W-1]};
        if (borrow_s) begin
            r_nxt_s = shifted_s;
        end else begin
            r_nxt_s = diff_s;
        end
        q_nxt_s = {q_r[DIVIDEND_W-2:0], ~borrow_s};
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (divisor == 8'd0) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_ITER) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= 16'd0;
            d_r         <= 8'd0;
            r_r         <= 9'd0;
            cnt_r       <= 5'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= 16'd0;
            remainder_r <= 8'd0;
            div_zero_r  <= 1'b0;
        end else begin
            // in_ready only rises the cycle after the result handshake.
            in_ready_r <= (state_nxt_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        q_r   <= dividend;
                        d_r   <= divisor;
                        r_r   <= 9'd0;
                        cnt_r <= 5'd0;
                    end
                end
                CALC: begin
                    q_r   <= q_nxt_s;
                    r_r   <= r_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == LAST_ITER) begin
                        quotient_r  <= q_nxt_s;
                        remainder_r <= r_nxt_s[DIVISOR_W-1:0];
                        div_zero_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Entering DONE without a valid result only happens on
                    // the zero-divisor path; publish its fixed result here.
                    if (!out_valid_r) begin
                        quotient_r  <= DIV_ZERO_QUOT;
                        remainder_r <= q_r[DIVISOR_W-1:0];
                        div_zero_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule : div_16_8_seq

// File: tb/tb_div_16_8_seq.sv
// Directed self-checking bench for div_16_8_seq.
module tb_div_16_8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_vec;
    int n_bad;

    div_16_8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got,
                             input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, counting edges; bounded so a hang becomes a miscompare.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full operation: present operands, accept, wait, check, handshake.
    task automatic run_div(input string tag, input logic [15:0] a,
                           input logic [7:0] b, input int unsigned exp_q,
                           input int unsigned exp_r, input int unsigned exp_dz,
                           input int unsigned exp_lat);
        int lat;
        check_val({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h5A;
        wait_out(lat);
        check_val({tag, ".lat"}, lat, exp_lat);
        check_val({tag, ".quot"}, quotient, exp_q);
        check_val({tag, ".rem"}, remainder, exp_r);
        check_val({tag, ".dz"}, div_zero, exp_dz);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, ".ov_clr"}, out_valid, 0);
        tick();
    endtask

    initial begin
        int lat;
        logic stable;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        #23;
        check_val("rst.in_ready", in_ready, 1);
        check_val("rst.out_valid", out_valid, 0);
        check_val("rst.quot", quotient, 0);
        check_val("rst.rem", remainder, 0);
        check_val("rst.dz", div_zero, 0);
        rst_n = 1'b1;
        tick();

        run_div("1000/7", 16'd1000, 8'd7, 142, 6, 0, 16);
        run_div("65535/255", 16'd65535, 8'd255, 257, 0, 0, 16);
        run_div("65535/1", 16'd65535, 8'd1, 65535, 0, 0, 16);
        run_div("0/9", 16'd0, 8'd9, 0, 0, 0, 16);
        run_div("5/200", 16'd5, 8'd200, 0, 5, 0, 16);
        run_div("0x1234/0", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1, 1);

        // Back-pressure: result must hold, new operands must be ignored.
        in_valid = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'h10;
        tick();
        dividend = 16'd5;
        divisor  = 8'd1;
        wait_out(lat);
        check_val("hold.lat", lat, 16);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || in_ready || quotient !== 16'h0FFF ||
                remainder !== 8'h0F) begin
                stable = 1'b0;
            end
        end
        check_val("hold.stable", stable, 1);
        check_val("hold.quot", quotient, 16'h0FFF);
        check_val("hold.rem", remainder, 8'h0F);
        out_ready = 1'b1;
        tick();
        check_val("hold.hs_ov", out_valid, 0);
        check_val("hold.hs_rdy", in_ready, 1);
        check_val("hold.quot_kept", quotient, 16'h0FFF);
        tick();
        check_val("hold.next_acc", in_ready, 0);
        in_valid  = 1'b0;
        wait_out(lat);
        check_val("5/1.lat", lat, 16);
        check_val("5/1.quot", quotient, 5);
        check_val("5/1.rem", remainder, 0);
        tick();
        out_ready = 1'b0;
        tick();

        // Reset in the middle of CALC abandons the operation.
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        check_val("midrst.in_ready", in_ready, 1);
        check_val("midrst.out_valid", out_valid, 0);
        check_val("midrst.quot", quotient, 0);
        check_val("midrst.rem", remainder, 0);
        check_val("midrst.dz", div_zero, 0);
        #12;
        rst_n = 1'b1;
        tick();
        run_div("40000/3", 16'd40000, 8'd3, 13333, 1, 0, 16);

        // Back-to-back with in_valid held high and out_ready high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'd300;
        divisor   = 8'd17;
        tick();
        dividend  = 16'd12345;
        divisor   = 8'd99;
        wait_out(lat);
        check_val("b2b1.lat", lat, 16);
        check_val("b2b1.quot", quotient, 17);
        check_val("b2b1.rem", remainder, 11);
        tick();
        check_val("b2b.hs_ov", out_valid, 0);
        check_val("b2b.hs_rdy", in_ready, 1);
        tick();
        check_val("b2b.acc2", in_ready, 0);
        in_valid = 1'b0;
        wait_out(lat);
        check_val("b2b2.lat", lat, 16);
        check_val("b2b2.quot", quotient, 124);
        check_val("b2b2.rem", remainder, 69);
        tick();
        out_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_div_16_8_seq
